pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline stage register. Replaces the hand-written per-stage registers (fetch/decode, decode/execute, execute/writeback).
- Adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush to a configurable bubble value, occupancy reporting and a saturating stall counter.
- One instance sits between each pair of pipeline stages. The payload is the packed stage bundle.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- BUBBLE, '0, payload value driven while empty and loaded on flush/reset. Lets a field such as op_type reset to 1.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready.
- CNT_W, 16, stall counter width (>=1).

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous flush: discard all held entries and any beat presented this cycle.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.
- out_data  output  WIDTH  head payload; equals BUBBLE when out_valid=0.
- occupancy  output  2  entries held (0..2; never exceeds 1 when SKID=0).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Definitions: accept = in_valid & in_ready & ~flush; pop = out_valid & out_ready.
- Reset (rstn=0 at posedge):
  - state EMPTY, out_valid=0, out_data=BUBBLE, skid entry=BUBBLE, occupancy=0, stall_cnt=0.
  - in_ready=1 from the first cycle after reset.
- Priority: reset > flush > normal operation.
- Flush, at posedge:
  - state EMPTY, out_valid=0, out_data=BUBBLE, skid entry=BUBBLE.
  - Any beat presented in the same cycle is dropped even if in_ready=1. Upstream treats it as flushed.
  - stall_cnt is not cleared by flush.
- Latency: 1 cycle. A beat accepted at edge N is visible on out_data/out_valid after edge N.
- Ordering is strictly FIFO. No beat is duplicated or lost except on flush/reset.
- SKID=1 state machine (states EMPTY, ONE, TWO):
  - in_ready = (state != TWO), driven from a register with no combinational path from out_ready.
  - EMPTY: accept -> ONE, main<=in_data.
  - ONE: accept & pop -> ONE, main<=in_data. accept & ~pop -> TWO, skid<=in_data. ~accept & pop -> EMPTY, main<=BUBBLE. Otherwise hold.
  - TWO: no accept possible. pop -> ONE, main<=skid, skid<=BUBBLE. Otherwise hold.
- SKID=0 behaviour:
  - in_ready = ~out_valid | out_ready (combinational).
  - accept -> main<=in_data, out_valid=1.
  - pop & ~accept -> out_valid=0, main<=BUBBLE.
  - Otherwise hold. The TWO state is unreachable.
- Hold: a held entry keeps its payload stable while out_ready=0. in_data changes do not affect stored data without accept.
- occupancy: 0/1/2 for EMPTY/ONE/TWO, registered and updated with the state.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & ~out_ready & ~flush.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Simultaneous flush & pop: the pop is not counted as a transfer. Downstream must also be flushed by the same control. Stage state goes to EMPTY.
- in_valid with in_ready=0: the beat is not taken. Upstream must hold in_data stable until accepted.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum {EMPTY, ONE, TWO} pipe_state_t (2-bit encoding 0/1/2, also driving occupancy).
  - Localparam for the occupancy width.
  - Packed stage-bundle typedefs (fd_bundle_t, de_bundle_t, ew_bundle_t) and their BUBBLE constants, e.g. op_type=1 in de_bundle_t.
- One sub-module: sat_counter (parametrised width; inc, clear inputs; saturating output), used for stall_cnt.

Test Plan:
- Reset with WIDTH=8, BUBBLE=8'hA5 -> out_valid=0, out_data=8'hA5, occupancy=0, stall_cnt=0, in_ready=1 one cycle after reset.
- SKID=1, out_ready=0, send 8'h11 then 8'h22 -> occupancy 1 then 2, in_ready=0; third beat 8'h33 held off. Raise out_ready -> outputs 11, 22, 33 in order, no gaps after the first.
- SKID=1, in_valid and out_ready held at 1 with the sequence 01..10 -> one beat out per cycle at 1-cycle latency, occupancy stays 1, stall_cnt unchanged.
- Occupancy=2, assert flush together with in_valid (8'h44) -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0, 8'h44 never appears; stall_cnt retains its value.
- CNT_W=3, out_valid=1 with out_ready=0 for 10 cycles -> stall_cnt counts 1..7 and stays at 7.
- SKID=0, out_ready toggled 1,0,1 with continuous input -> in_ready equals ~out_valid | out_ready combinationally, occupancy never exceeds 1, no beat lost.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage registers: handshake state, occupancy width
// and the packed inter-stage bundles with their bubble values.
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    // Fetch -> decode; a bubble carries the canonical nop encoding.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fd_bundle_t;

    localparam fd_bundle_t FD_BUBBLE = '{pc: 32'h0000_0000, instr: 32'h0000_0013};

    typedef struct packed {
        logic [3:0]  op_type;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } de_bundle_t;

    // op_type 1 is the no-operation class downstream decoders ignore.
    localparam de_bundle_t DE_BUBBLE = '{op_type: 4'd1, rd: 5'd0, rs1: 5'd0,
                                         rs2: 5'd0, imm: 32'h0000_0000};

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] result;
    } ew_bundle_t;

    localparam ew_bundle_t EW_BUBBLE = '{wb_en: 1'b0, rd: 5'd0, result: 32'h0000_0000};

    function automatic logic [OCC_W-1:0] state_to_occ(input pipe_state_t s);
        return OCC_W'(s);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_C = {W{1'b1}};
    localparam logic [W-1:0] ONE_C = W'(1'b1);

    logic [W-1:0] count_r;

    // Count register: reset/clear to zero, increment until saturated.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc && (count_r != MAX_C)) begin
            count_r <= count_r + ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, flush-to-bubble, occupancy and saturating stall count.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter bit               SKID   = 1'b1,
    parameter int unsigned      CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t      state_r;
    pipe_state_t      state_nxt_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] main_nxt_s;
    logic [WIDTH-1:0] skid_r;
    logic [WIDTH-1:0] skid_nxt_s;
    logic             out_valid_r;
    logic             in_ready_r;
    logic [OCC_W-1:0] occ_r;
    logic             in_ready_s;
    logic             accept_s;
    logic             pop_s;
    logic             stall_inc_s;

    // Handshake qualifiers; the skid variant never looks at out_ready for in_ready.
    always_comb begin
        if (SKID) begin
            in_ready_s = in_ready_r;
        end else begin
            in_ready_s = ~out_valid_r | out_ready;
        end
        accept_s    = in_valid & in_ready_s & ~flush;
        pop_s       = out_valid_r & out_ready;
        stall_inc_s = out_valid_r & ~out_ready & ~flush;
    end

    // State and payload registers; flush folds into the next-state logic.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= EMPTY;
            main_r      <= BUBBLE;
            skid_r      <= BUBBLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occ_r       <= '0;
        end else begin
            state_r     <= state_nxt_s;
            main_r      <= main_nxt_s;
            skid_r      <= skid_nxt_s;
            out_valid_r <= (state_nxt_s != EMPTY);
            in_ready_r  <= (state_nxt_s != TWO);
            occ_r       <= state_to_occ(state_nxt_s);
        end
    end

    // Next-state: without a skid buffer an accept while full always coincides with a pop.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ONE;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && !pop_s) begin
                        state_nxt_s = SKID ? TWO : ONE;
                    end else if (!accept_s && pop_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                TWO: begin
                    if (pop_s) begin
                        state_nxt_s = ONE;
                    end else begin
                        state_nxt_s = TWO;
                    end
                end
                default: state_nxt_s = EMPTY;
            endcase
        end
    end

    // Payload movement: main is always the head, skid the second entry.
    always_comb begin
        main_nxt_s = main_r;
        skid_nxt_s = skid_r;
        if (flush) begin
            main_nxt_s = BUBBLE;
            skid_nxt_s = BUBBLE;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        main_nxt_s = in_data;
                    end else begin
                        main_nxt_s = main_r;
                    end
                end
                ONE: begin
                    if (accept_s && pop_s) begin
                        main_nxt_s = in_data;
                    end else if (accept_s) begin
                        skid_nxt_s = in_data;
                    end else if (pop_s) begin
                        main_nxt_s = BUBBLE;
                    end else begin
                        main_nxt_s = main_r;
                    end
                end
                TWO: begin
                    if (pop_s) begin
                        main_nxt_s = skid_r;
                        skid_nxt_s = BUBBLE;
                    end else begin
                        main_nxt_s = main_r;
                    end
                end
                default: begin
                    main_nxt_s = BUBBLE;
                    skid_nxt_s = BUBBLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clear (1'b0),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign occupancy = occ_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid and one non-skid instance share stimulus;
// a queue-based reference model predicts contents, readiness and stall counts.
module tb_pipe_stage_reg;

    localparam logic [7:0] BUB     = 8'hA5;
    localparam int         CNT_MAX = 7;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic [1:0] in_ready_w;
    logic [1:0] out_valid_w;
    logic [7:0] out_data_w [2];
    logic [1:0] occ_w      [2];
    logic [2:0] stall_w    [2];

    logic [7:0] exp_q   [2][$];
    int         stall_m [2];
    int         checks;
    int         errors;

    pipe_stage_reg #(.WIDTH(8), .BUBBLE(8'hA5), .SKID(1'b0), .CNT_W(3)) dut0 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
        .occupancy(occ_w[0]), .stall_cnt(stall_w[0])
    );

    pipe_stage_reg #(.WIDTH(8), .BUBBLE(8'hA5), .SKID(1'b1), .CNT_W(3)) dut1 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
        .occupancy(occ_w[1]), .stall_cnt(stall_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Readiness derived from capacity: 2 slots with skid, else 1 slot freed by a same-cycle pop.
    function automatic logic model_ready(input int k, input logic r);
        if (k == 1) return exp_q[1].size() < 2;
        return (exp_q[0].size() == 0) || r;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h", nm, k, act, exp);
        end
    endtask

    // Monitor: compares each DUT against the model, then retires popped/flushed entries.
    always @(negedge clk) begin
        int  sz;
        logic hv;
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                exp_q[k].delete();
                stall_m[k] = 0;
            end else begin
                sz = exp_q[k].size();
                hv = (sz > 0);
                chk("out_valid", k, 32'(out_valid_w[k]), 32'(hv));
                chk("out_data", k, 32'(out_data_w[k]), hv ? 32'(exp_q[k][0]) : 32'(BUB));
                chk("occupancy", k, 32'(occ_w[k]), 32'(sz));
                chk("in_ready", k, 32'(in_ready_w[k]), 32'(model_ready(k, out_ready)));
                chk("stall_cnt", k, 32'(stall_w[k]), 32'(stall_m[k]));
                if (hv && !out_ready && !flush && stall_m[k] < CNT_MAX) stall_m[k]++;
                if (flush) exp_q[k].delete();
                else if (hv && out_ready) void'(exp_q[k].pop_front());
            end
        end
    end

    // One cycle of stimulus; accepted beats are pushed after the monitor has retired this cycle's pop.
    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
        logic [1:0] acc;
        @(posedge clk);
        #2;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        for (int k = 0; k < 2; k++) acc[k] = v && !f && rstn && model_ready(k, r);
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) if (acc[k]) exp_q[k].push_back(d);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill with out_ready low, third beat held off, then drain in order.
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b1, 1'b0);
        drive(1'b1, 8'h33, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Back-to-back streaming.
        for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush while full, with a beat presented in the same cycle.
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'h66, 1'b0, 1'b0);
        drive(1'b1, 8'h44, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Stall counter saturation.
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        repeat (10) drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // out_ready toggling under continuous input.
        for (int i = 0; i < 12; i++) drive(1'b1, 8'(8'h80 + i), (i % 3) != 1, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Mid-run reset clears a saturated stall counter.
        do_reset();
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomised traffic, two pressure profiles.
        repeat (1500) drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                            $urandom_range(0, 40) == 0);
        repeat (1500) drive($urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
                            $urandom_range(0, 60) == 0);
        repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
